// File: rtl/cofi_ctrl.sv
// cofi_ctrl: measures the active line width of incoming video and decides,
// once per frame at the rising edge of vertical blank, whether the
// horizontal colour-blend stage is enabled.
module cofi_ctrl #(
    parameter int unsigned WIDTH_BITS    = 11,
    parameter int unsigned LOWRES_THRESH = 400,
    parameter int unsigned STABLE_FRAMES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pix_ce,
    input  logic                  hblank,
    input  logic                  vblank,
    input  logic [1:0]            cfg_mode,
    output logic                  cofi_enable,
    output logic [WIDTH_BITS-1:0] active_width,
    output logic                  width_valid,
    output logic                  lowres
);

    typedef enum logic [1:0] {
        S_SYNC    = 2'd0,
        S_MEASURE = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t                state;
    logic                  hblank_d;
    logic                  vblank_d;
    logic                  hrise;
    logic                  vrise;
    logic [WIDTH_BITS-1:0] line_cnt;
    logic [WIDTH_BITS-1:0] line_max;
    logic [WIDTH_BITS-1:0] frame_w;
    logic [WIDTH_BITS-1:0] prev_w;
    logic [2:0]            stable;
    logic [2:0]            s_next;
    logic                  w_zero;
    logic                  w_low;
    logic                  s_ok;

    assign hrise = hblank & ~hblank_d;
    assign vrise = vblank & ~vblank_d;

    // Delayed blanking signals for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hblank_d <= 1'b0;
            vblank_d <= 1'b0;
        end else begin
            hblank_d <= hblank;
            vblank_d <= vblank;
        end
    end

    // Per-line pixel count and per-frame maximum line width.
    // The line_max clear on vrise is done here for both S_SYNC and S_MEASURE;
    // vrise cannot occur in S_COMMIT, so it is state independent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt <= '0;
            line_max <= '0;
        end else if (vblank) begin
            line_cnt <= '0;
            if (vrise) begin
                line_max <= '0;
            end
        end else if (hrise) begin
            if (line_cnt > line_max) begin
                line_max <= line_cnt;
            end
            line_cnt <= '0;
        end else if (pix_ce && !hblank && (line_cnt != '1)) begin
            line_cnt <= line_cnt + 1'b1;
        end
    end

    // Commit-time helpers: next stability count and width classification.
    always_comb begin
        w_zero = (frame_w == '0);
        w_low  = (32'(frame_w) < LOWRES_THRESH);
        s_next = 3'd0;
        if (!w_zero) begin
            if (frame_w == prev_w) begin
                s_next = (stable == 3'd7) ? 3'd7 : stable + 3'd1;
            end else begin
                s_next = 3'd1;
            end
        end
        s_ok = (32'(s_next) >= STABLE_FRAMES);
    end

    // Frame state machine with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_SYNC;
            frame_w      <= '0;
            prev_w       <= '0;
            stable       <= '0;
            cofi_enable  <= 1'b0;
            active_width <= '0;
            width_valid  <= 1'b0;
            lowres       <= 1'b0;
        end else begin
            case (state)
                S_SYNC: begin
                    if (vrise) begin
                        state <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (vrise) begin
                        frame_w <= line_max;
                        state   <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    stable       <= s_next;
                    width_valid  <= ~w_zero;
                    prev_w       <= frame_w;
                    active_width <= frame_w;
                    lowres       <= ~w_zero & w_low;
                    case (cfg_mode)
                        2'b01: cofi_enable <= 1'b1;
                        2'b10: begin
                            if (s_ok && !w_zero) begin
                                cofi_enable <= w_low;
                            end
                        end
                        default: cofi_enable <= 1'b0;
                    endcase
                    state <= S_MEASURE;
                end
                default: state <= S_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_cofi_ctrl.sv
// tb_cofi_ctrl: randomized video timing against a frame-level reference model.
module tb_cofi_ctrl;

    localparam int W    = 11;
    localparam int THR  = 400;
    localparam int SF   = 2;
    localparam int MAXW = 2047;

    logic         clk      = 1'b0;
    logic         reset_n  = 1'b0;
    logic         pix_ce   = 1'b0;
    logic         hblank   = 1'b1;
    logic         vblank   = 1'b0;
    logic [1:0]   cfg_mode = 2'b00;
    logic         cofi_enable;
    logic [W-1:0] active_width;
    logic         width_valid;
    logic         lowres;

    int checks = 0;
    int errors = 0;

    cofi_ctrl #(
        .WIDTH_BITS   (W),
        .LOWRES_THRESH(THR),
        .STABLE_FRAMES(SF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_ce      (pix_ce),
        .hblank      (hblank),
        .vblank      (vblank),
        .cfg_mode    (cfg_mode),
        .cofi_enable (cofi_enable),
        .active_width(active_width),
        .width_valid (width_valid),
        .lowres      (lowres)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  cur_line, frame_max, pend_w;
    bit  synced, pend, hb_prev, vb_prev;
    int  hist[$];
    bit  exp_en, exp_valid, exp_low;
    int  exp_w;

    task automatic commit(input int w, input int mode);
        int run;
        hist.push_back(w);
        if (hist.size() > 16) hist.delete(0);
        run = 0;
        if (w != 0) begin
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != w) break;
                run++;
            end
        end
        if (run > 7) run = 7;
        exp_w     = w;
        exp_valid = (w != 0);
        exp_low   = (w != 0) && (w < THR);
        case (mode)
            1: exp_en = 1'b1;
            2: if (w != 0 && run >= SF) exp_en = (w < THR);
            default: exp_en = 1'b0;
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                cur_line = 0; frame_max = 0; pend_w = 0;
                synced = 0; pend = 0; hb_prev = 0; vb_prev = 0;
                hist.delete();
                exp_en = 0; exp_valid = 0; exp_low = 0; exp_w = 0;
            end else begin
                if (pend) begin
                    commit(pend_w, int'(cfg_mode));
                    pend = 0;
                end
                if (vblank && !vb_prev) begin
                    if (synced) begin
                        pend   = 1;
                        pend_w = frame_max;
                    end
                    synced    = 1;
                    frame_max = 0;
                end
                if (vblank) begin
                    cur_line = 0;
                end else if (hblank && !hb_prev) begin
                    if ((cur_line > MAXW ? MAXW : cur_line) > frame_max)
                        frame_max = (cur_line > MAXW) ? MAXW : cur_line;
                    cur_line = 0;
                end else if (pix_ce && !hblank) begin
                    cur_line++;
                end
                hb_prev = hblank;
                vb_prev = vblank;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset_n) begin
                check("cmp_enable", cofi_enable, exp_en);
                check("cmp_width", active_width, exp_w);
                check("cmp_valid", width_valid, exp_valid);
                check("cmp_lowres", lowres, exp_low);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic outs(input string tag, input bit en, input int w, input bit v, input bit lo);
        check({tag, "_enable"}, cofi_enable, en);
        check({tag, "_width"}, active_width, w);
        check({tag, "_valid"}, width_valid, v);
        check({tag, "_lowres"}, lowres, lo);
    endtask

    task automatic one_line(input int w, input bit dense);
        @(negedge clk); hblank = 0; pix_ce = 0;
        for (int i = 0; i < w; i++) begin
            @(negedge clk); pix_ce = 1;
            if (!dense && $urandom_range(0, 3) == 0) begin
                @(negedge clk); pix_ce = 0;
            end
        end
        // a pulse coincident with the hblank edge must not count
        @(negedge clk); pix_ce = 1'($urandom_range(0, 1)); hblank = 1;
        repeat ($urandom_range(2, 5)) begin
            @(negedge clk); pix_ce = 1'($urandom_range(0, 1));
        end
        pix_ce = 0;
    endtask

    task automatic frame(input int w, input int nl, input bit dense, input int sw_mode);
        int big;
        int wl;
        // blanking with hblank edges that must be ignored while vblank is high
        repeat ($urandom_range(2, 6)) begin
            @(negedge clk);
            hblank = 1'($urandom_range(0, 1));
            pix_ce = 1'($urandom_range(0, 1));
        end
        @(negedge clk); vblank = 0; hblank = 1; pix_ce = 0;
        big = $urandom_range(0, nl - 1);
        for (int l = 0; l < nl; l++) begin
            wl = (l == big) ? w : $urandom_range(0, w);
            one_line(wl, dense);
            if (sw_mode >= 0 && l == 0) cfg_mode = 2'(sw_mode);
        end
    endtask

    task automatic empty_frame();
        @(negedge clk); vblank = 0; hblank = 1;
        repeat ($urandom_range(3, 8)) begin
            @(negedge clk); pix_ce = 1'($urandom_range(0, 1));
        end
        pix_ce = 0;
    endtask

    task automatic vsync(output logic en_at_n);
        @(negedge clk); vblank = 1; hblank = 1; pix_ce = 0;
        @(negedge clk); en_at_n = cofi_enable;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 reset_n = 0;
        #1 outs("rst_async", 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic e;
        int   wsel[6];
        int   w, reps, nl;
        wsel = '{128, 256, 399, 400, 401, 640};

        // auto low-res
        cfg_mode = 2'b10;
        repeat (3) @(negedge clk);
        reset_n = 1;
        frame(256, 3, 0, -1); vsync(e);
        check("lo_v1_enable", cofi_enable, 0);
        frame(256, 3, 0, -1); vsync(e);
        outs("lo_v2", 0, 256, 1, 1);
        frame(256, 3, 0, -1); vsync(e);
        check("lo_v3_at_n", e, 0);
        outs("lo_v3", 1, 256, 1, 1);
        frame(256, 3, 0, -1); vsync(e);
        outs("lo_v4", 1, 256, 1, 1);

        // auto high-res
        do_reset();
        for (int f = 0; f < 4; f++) begin
            frame(640, 2, 1, -1); vsync(e);
        end
        outs("hi", 0, 640, 1, 0);

        // forced on, switched mid-frame
        do_reset();
        cfg_mode = 2'b00;
        frame(300, 2, 0, -1); vsync(e);
        frame(300, 2, 0, 1); vsync(e);
        check("force_at_n", e, 0);
        outs("force", 1, 300, 1, 1);

        // width change and empty frame
        do_reset();
        cfg_mode = 2'b10;
        for (int f = 0; f < 3; f++) begin
            frame(256, 2, 0, -1); vsync(e);
        end
        outs("wc_stable", 1, 256, 1, 1);
        empty_frame(); vsync(e);
        outs("empty", 1, 0, 0, 0);
        frame(256, 2, 0, -1); vsync(e);
        outs("wc_after_empty", 1, 256, 1, 1);
        frame(512, 2, 0, -1); vsync(e);
        outs("wc_512a", 1, 512, 1, 0);
        frame(512, 2, 0, -1); vsync(e);
        outs("wc_512b", 0, 512, 1, 0);

        // saturation
        frame(3000, 1, 1, -1); vsync(e);
        outs("sat", 0, 2047, 1, 0);

        // reset mid-line while enabled
        cfg_mode = 2'b01;
        frame(200, 1, 0, -1); vsync(e);
        check("pre_rst_enable", cofi_enable, 1);
        @(negedge clk); vblank = 0; hblank = 1;
        @(negedge clk); hblank = 0;
        repeat (10) begin
            @(negedge clk); pix_ce = 1'($urandom_range(0, 1));
        end
        #3 reset_n = 0;
        #1 outs("rst_midline", 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        cfg_mode = 2'b10;
        reset_n = 1;
        repeat (20) begin
            @(negedge clk); pix_ce = 1'($urandom_range(0, 1));
        end
        pix_ce = 0;
        one_line(100, 0);
        vsync(e);
        check("rst_sync_enable", cofi_enable, 0);
        frame(256, 2, 0, -1); vsync(e);
        check("rst_f1_enable", cofi_enable, 0);
        frame(256, 2, 0, -1); vsync(e);
        check("rst_f2_enable", cofi_enable, 1);

        // randomized sequences, checked by the model every cycle
        for (int k = 0; k < 8; k++) begin
            w    = wsel[$urandom_range(0, 5)];
            reps = $urandom_range(1, 3);
            for (int r = 0; r < reps; r++) begin
                nl = $urandom_range(1, 2);
                if ($urandom_range(0, 9) == 0) begin
                    empty_frame();
                end else begin
                    frame(w, nl, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
                end
                vsync(e);
            end
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
